// File: rtl/mem_boot_loader.sv
// Command-driven BRAM preloader: streams words into one of NUM_CH BRAM channels,
// optionally reads them back through the debug port to compare, then releases the core stall.
module mem_boot_loader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int NUM_CH     = 2,
   parameter int WORD_BYTES = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [1:0]                   cmd_op,
   input  logic [2:0]                   cmd_ch,
   input  logic [ADDR_WIDTH-1:0]        cmd_base,
   input  logic [ADDR_WIDTH-1:0]        cmd_count,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [DATA_WIDTH-1:0]        s_data,
   output logic [ADDR_WIDTH-1:0]        mem_w_addr,
   output logic [DATA_WIDTH-1:0]        mem_w_dat,
   output logic [NUM_CH-1:0]            mem_w_enb,
   output logic [ADDR_WIDTH-1:0]        dbg_addr,
   input  logic [NUM_CH*DATA_WIDTH-1:0] dbg_data,
   output logic                         cpu_stall,
   output logic                         busy,
   output logic                         err,
   output logic [ADDR_WIDTH-1:0]        err_addr
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR      = 3'd1,
      ST_VRD     = 3'd2,
      ST_VCMP    = 3'd3,
      ST_RUNNING = 3'd4
   } state_t;

   localparam logic [1:0]            OP_WRITE  = 2'b00;
   localparam logic [1:0]            OP_VERIFY = 2'b01;
   localparam logic [1:0]            OP_RUN    = 2'b10;
   localparam logic [1:0]            OP_HALT   = 2'b11;
   localparam logic [3:0]            NUM_CH_L  = 4'(NUM_CH);
   localparam logic [ADDR_WIDTH-1:0] STRIDE    = ADDR_WIDTH'(WORD_BYTES);
   localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

   function automatic logic [NUM_CH-1:0] ch_onehot(input logic [2:0] ch);
      logic [NUM_CH-1:0] v;
      v = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         v[k] = (ch == 3'(k));
      end
      return v;
   endfunction

   state_t                  state_r, state_s;
   logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
   logic [ADDR_WIDTH-1:0]   count_r, count_s;
   logic [2:0]              ch_r, ch_s;
   logic [ADDR_WIDTH-1:0]   w_addr_r, w_addr_s;
   logic [DATA_WIDTH-1:0]   w_dat_r, w_dat_s;
   logic [NUM_CH-1:0]       w_enb_r, w_enb_s;
   logic [ADDR_WIDTH-1:0]   dbg_addr_r, dbg_addr_s;
   logic                    err_r, err_s;
   logic [ADDR_WIDTH-1:0]   err_addr_r, err_addr_s;
   logic                    cmd_ready_r, s_ready_r, cpu_stall_r, busy_r;
   logic [NUM_CH-1:0]       mism_s;
   logic                    mismatch_s;
   logic                    ch_bad_s;

   assign ch_bad_s   = ({1'b0, cmd_ch} >= NUM_CH_L);
   assign cmd_ready  = cmd_ready_r;
   assign s_ready    = s_ready_r;
   assign cpu_stall  = cpu_stall_r;
   assign busy       = busy_r;
   assign mem_w_addr = w_addr_r;
   assign mem_w_dat  = w_dat_r;
   assign mem_w_enb  = w_enb_r;
   assign dbg_addr   = dbg_addr_r;
   assign err        = err_r;
   assign err_addr   = err_addr_r;

   // Per-channel readback compare, then select the active channel
   always_comb begin
      mism_s = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         mism_s[k] = (dbg_data[k*DATA_WIDTH +: DATA_WIDTH] != s_data);
      end
      mismatch_s = |(mism_s & ch_onehot(ch_r));
   end

   // Next-state and datapath decode
   always_comb begin
      state_s    = state_r;
      addr_s     = addr_r;
      count_s    = count_r;
      ch_s       = ch_r;
      w_addr_s   = w_addr_r;
      w_dat_s    = w_dat_r;
      w_enb_s    = '0;
      dbg_addr_s = dbg_addr_r;
      err_s      = err_r;
      err_addr_s = err_addr_r;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_r) begin
               addr_s  = cmd_base;
               count_s = cmd_count;
               ch_s    = cmd_ch;
               case (cmd_op)
                  OP_WRITE, OP_VERIFY: begin
                     if (cmd_count == '0) begin
                        state_s = ST_IDLE;
                     end else if (ch_bad_s) begin
                        if (!err_r) begin
                           err_s      = 1'b1;
                           err_addr_s = cmd_base;
                        end else begin
                           err_s = err_r;
                        end
                     end else if (cmd_op == OP_WRITE) begin
                        state_s = ST_WR;
                     end else begin
                        state_s    = ST_VRD;
                        dbg_addr_s = cmd_base;
                     end
                  end
                  OP_RUN:  state_s = ST_RUNNING;
                  OP_HALT: state_s = ST_IDLE;
                  default: state_s = ST_IDLE;
               endcase
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WR: begin
            if (s_valid && s_ready_r) begin
               w_addr_s = addr_r;
               w_dat_s  = s_data;
               w_enb_s  = ch_onehot(ch_r);
               addr_s   = addr_r + STRIDE;
               count_s  = count_r - ONE;
               if (count_r == ONE) begin
                  state_s = ST_IDLE;
               end else begin
                  state_s = ST_WR;
               end
            end else begin
               state_s = ST_WR;
            end
         end
         ST_VRD: begin
            state_s = ST_VCMP;
         end
         ST_VCMP: begin
            if (s_valid && s_ready_r) begin
               if (mismatch_s && !err_r) begin
                  err_s      = 1'b1;
                  err_addr_s = addr_r;
               end else begin
                  err_s = err_r;
               end
               addr_s  = addr_r + STRIDE;
               count_s = count_r - ONE;
               if (count_r == ONE) begin
                  state_s = ST_IDLE;
               end else begin
                  state_s    = ST_VRD;
                  dbg_addr_s = addr_r + STRIDE;
               end
            end else begin
               state_s = ST_VCMP;
            end
         end
         ST_RUNNING: begin
            // Non-HALT commands are accepted and dropped while the core runs
            if (cmd_valid && cmd_ready_r && (cmd_op == OP_HALT)) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RUNNING;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State, datapath and registered handshake/status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         addr_r      <= '0;
         count_r     <= '0;
         ch_r        <= 3'd0;
         w_addr_r    <= '0;
         w_dat_r     <= '0;
         w_enb_r     <= '0;
         dbg_addr_r  <= '0;
         err_r       <= 1'b0;
         err_addr_r  <= '0;
         cmd_ready_r <= 1'b1;
         s_ready_r   <= 1'b0;
         cpu_stall_r <= 1'b1;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         addr_r      <= addr_s;
         count_r     <= count_s;
         ch_r        <= ch_s;
         w_addr_r    <= w_addr_s;
         w_dat_r     <= w_dat_s;
         w_enb_r     <= w_enb_s;
         dbg_addr_r  <= dbg_addr_s;
         err_r       <= err_s;
         err_addr_r  <= err_addr_s;
         cmd_ready_r <= (state_s == ST_IDLE) || (state_s == ST_RUNNING);
         s_ready_r   <= (state_s == ST_WR) || (state_s == ST_VCMP);
         cpu_stall_r <= (state_s != ST_RUNNING);
         busy_r      <= (state_s != ST_IDLE) && (state_s != ST_RUNNING);
      end
   end

endmodule

// File: tb/tb_mem_boot_loader.sv
// Randomized scoreboard bench for mem_boot_loader with a two-channel BRAM model behind
// the write/debug ports and a word-level reference of memory contents and error status.
module tb_mem_boot_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b00;
   logic [2:0]  cmd_ch = 3'd0;
   logic [9:0]  cmd_base = 10'd0;
   logic [9:0]  cmd_count = 10'd0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [31:0] s_data = 32'd0;
   logic [9:0]  mem_w_addr;
   logic [31:0] mem_w_dat;
   logic [1:0]  mem_w_enb;
   logic [9:0]  dbg_addr;
   logic [63:0] dbg_data = 64'd0;
   logic        cpu_stall;
   logic        busy;
   logic        err;
   logic [9:0]  err_addr;

   mem_boot_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .NUM_CH(2), .WORD_BYTES(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_ch(cmd_ch),
      .cmd_base(cmd_base), .cmd_count(cmd_count),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .mem_w_addr(mem_w_addr), .mem_w_dat(mem_w_dat), .mem_w_enb(mem_w_enb),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data),
      .cpu_stall(cpu_stall), .busy(busy), .err(err), .err_addr(err_addr)
   );

   always #5 clk = ~clk;

   localparam logic [1:0] OP_WRITE = 2'b00, OP_VERIFY = 2'b01, OP_RUN = 2'b10, OP_HALT = 2'b11;

   typedef struct packed {
      logic [9:0]  a;
      logic [31:0] d;
      logic [1:0]  e;
   } wr_t;

   int          checks = 0;
   int          errors = 0;
   wr_t         wq[$];
   logic [31:0] bram    [2][256];
   logic [31:0] ref_mem [2][256];
   logic        ref_err = 1'b0;
   logic [9:0]  ref_err_addr = 10'd0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // BRAM model: synchronous write ports, 1-cycle debug read
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (mem_w_enb[k]) bram[k][mem_w_addr[9:2]] <= mem_w_dat;
      end
      dbg_data <= {bram[1][dbg_addr[9:2]], bram[0][dbg_addr[9:2]]};
   end

   // Write monitor: every enable pulse must match the next expected write
   always @(negedge clk) begin
      wr_t e;
      if (rst && (mem_w_enb !== 2'b00)) begin
         if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_write: got addr %0h enb %b want no write", mem_w_addr, mem_w_enb);
         end else begin
            e = wq.pop_front();
            chk("write", {20'd0, mem_w_addr, mem_w_dat, mem_w_enb}, {20'd0, e});
            chk("stall_during_write", {63'd0, cpu_stall}, 64'd1);
         end
      end
   end

   task automatic send_cmd(input logic [1:0] op, input int ch, input logic [9:0] base, input logic [9:0] cnt);
      int n;
      cmd_op = op; cmd_ch = 3'(ch); cmd_base = base; cmd_count = cnt; cmd_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (cmd_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("cmd_ready_timeout", {63'd0, cmd_ready}, 64'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] d, input int bub);
      int n;
      repeat (bub) begin
         @(posedge clk); #1;
      end
      s_valid = 1'b1; s_data = d;
      n = 0;
      @(negedge clk);
      while (s_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("s_ready_timeout", {63'd0, s_ready}, 64'd1);
      else chk("busy_in_transfer", {63'd0, busy}, 64'd1);
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   function automatic int bubbles(input int mode, input int i);
      if (mode == 1) return int'($urandom_range(0, 2));
      if (mode == 2) return (i % 2 == 1) ? 2 : 0;
      return 0;
   endfunction

   task automatic do_write(input int ch, input logic [9:0] base, input int cnt, input int mode);
      logic [9:0]  a;
      logic [31:0] d;
      logic [1:0]  en;
      en = 2'(1 << ch);
      send_cmd(OP_WRITE, ch, base, 10'(cnt));
      for (int i = 0; i < cnt; i++) begin
         a = base + 10'(4 * i);
         d = $urandom;
         wq.push_back({a, d, en});
         ref_mem[ch][a[9:2]] = d;
         send_word(d, bubbles(mode, i));
      end
      @(negedge clk);
      chk("cmd_ready_after_write", {63'd0, cmd_ready}, 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic do_verify(input int ch, input logic [9:0] base, input int cnt, input int bad, input int mode);
      logic [9:0]  a;
      logic [31:0] w;
      send_cmd(OP_VERIFY, ch, base, 10'(cnt));
      for (int i = 0; i < cnt; i++) begin
         a = base + 10'(4 * i);
         w = ref_mem[ch][a[9:2]];
         if (i == bad) w = w ^ 32'h0000_0100;
         if (w != ref_mem[ch][a[9:2]] && !ref_err) begin
            ref_err      = 1'b1;
            ref_err_addr = a;
         end
         send_word(w, bubbles(mode, i));
      end
      @(negedge clk);
      chk("cmd_ready_after_verify", {63'd0, cmd_ready}, 64'd1);
      chk("err", {63'd0, err}, {63'd0, ref_err});
      chk("err_addr", {54'd0, err_addr}, {54'd0, ref_err_addr});
      @(posedge clk); #1;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd1);
      chk({tag, "_cpu_stall"}, {63'd0, cpu_stall}, 64'd1);
      chk({tag, "_s_ready"},   {63'd0, s_ready}, 64'd0);
      chk({tag, "_busy"},      {63'd0, busy}, 64'd0);
      chk({tag, "_enb"},       {62'd0, mem_w_enb}, 64'd0);
      chk({tag, "_err"},       {63'd0, err}, 64'd0);
      chk({tag, "_err_addr"},  {54'd0, err_addr}, 64'd0);
      chk({tag, "_w_addr"},    {54'd0, mem_w_addr}, 64'd0);
      chk({tag, "_w_dat"},     {32'd0, mem_w_dat}, 64'd0);
      chk({tag, "_dbg_addr"},  {54'd0, dbg_addr}, 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int          ch;
      int          mm;
      logic [31:0] d;
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 256; j++) begin
            bram[k][j]    = 32'd0;
            ref_mem[k][j] = 32'd0;
         end
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("stall_after_release", {63'd0, cpu_stall}, 64'd1);
      @(posedge clk); #1;

      // Directed loads, including an address wrap on ch1
      do_write(0, 10'h000, 7, 0);
      do_write(1, 10'h3F8, 3, 0);
      do_write(0, 10'h040, 4, 2);
      repeat (6) do_write(int'($urandom_range(0, 1)), {8'($urandom_range(0, 255)), 2'b00},
                          int'($urandom_range(1, 8)), 1);

      send_cmd(OP_WRITE, 0, 10'h080, 10'd0);
      @(negedge clk);
      chk("count0_busy", {63'd0, busy}, 64'd0);
      chk("count0_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      @(posedge clk); #1;

      // Matching readbacks leave err clear
      do_verify(1, 10'h3F8, 3, -1, 0);
      do_verify(0, 10'h000, 7, -1, 2);
      do_verify(0, 10'h040, 4, -1, 1);
      repeat (3) do_verify(int'($urandom_range(0, 1)), {8'($urandom_range(0, 255)), 2'b00},
                           int'($urandom_range(1, 8)), -1, 1);

      // Release the core; only HALT is honoured while running
      send_cmd(OP_RUN, 0, 10'h000, 10'd0);
      @(negedge clk);
      chk("run_stall", {63'd0, cpu_stall}, 64'd0);
      chk("run_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      chk("run_s_ready", {63'd0, s_ready}, 64'd0);
      chk("run_busy", {63'd0, busy}, 64'd0);
      @(posedge clk); #1;
      s_valid = 1'b1; s_data = $urandom;
      send_cmd(OP_WRITE, 0, 10'h000, 10'd2);
      @(negedge clk);
      chk("run_ignores_write", {63'd0, cpu_stall}, 64'd0);
      repeat (2) @(posedge clk);
      #1 s_valid = 1'b0;
      send_cmd(OP_HALT, 0, 10'h000, 10'd0);
      @(negedge clk);
      chk("halt_stall", {63'd0, cpu_stall}, 64'd1);
      chk("halt_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      @(posedge clk); #1;
      send_cmd(OP_HALT, 0, 10'h000, 10'd0);
      @(negedge clk);
      chk("idle_halt_stall", {63'd0, cpu_stall}, 64'd1);
      @(posedge clk); #1;

      // Reset while the third of seven words is being written
      send_cmd(OP_WRITE, 0, 10'h100, 10'd7);
      for (int i = 0; i < 3; i++) begin
         d = $urandom;
         if (i < 2) begin
            wq.push_back({10'h100 + 10'(4 * i), d, 2'b01});
            ref_mem[0][8'h40 + 8'(i)] = d;
         end
         send_word(d, 0);
      end
      #1 rst = 1'b0;
      #1;
      chk("abort_enb", {62'd0, mem_w_enb}, 64'd0);
      chk("abort_stall", {63'd0, cpu_stall}, 64'd1);
      chk("abort_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      chk("abort_busy", {63'd0, busy}, 64'd0);
      ref_err = 1'b0; ref_err_addr = 10'd0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      do_write(0, 10'h100, 7, 1);
      do_verify(0, 10'h100, 7, -1, 0);

      // First mismatch is captured (wraps to 0x000); a later one is ignored
      do_verify(1, 10'h3F8, 3, 2, 0);
      do_verify(0, 10'h000, 7, 5, 2);

      // Reset clears err; an out-of-range channel sets it without writing
      #1 rst = 1'b0;
      #1;
      chk("reset_clears_err", {63'd0, err}, 64'd0);
      ref_err = 1'b0; ref_err_addr = 10'd0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b1; s_data = $urandom;
      send_cmd(OP_WRITE, 2, 10'h2A4, 10'd3);
      ref_err = 1'b1; ref_err_addr = 10'h2A4;
      @(negedge clk);
      chk("badch_err", {63'd0, err}, {63'd0, ref_err});
      chk("badch_err_addr", {54'd0, err_addr}, {54'd0, ref_err_addr});
      chk("badch_busy", {63'd0, busy}, 64'd0);
      repeat (3) @(posedge clk);
      #1 s_valid = 1'b0;
      send_cmd(OP_VERIFY, 7, 10'h1F0, 10'd2);
      @(negedge clk);
      chk("badch2_err_addr", {54'd0, err_addr}, {54'd0, ref_err_addr});
      @(posedge clk); #1;

      // Final memory image must match the reference exactly
      for (int k = 0; k < 2; k++) begin
         ch = k;
         mm = 0;
         for (int j = 0; j < 256; j++) begin
            if (bram[ch][j] !== ref_mem[ch][j]) mm++;
         end
         chk("bram_image", 64'(mm), 64'd0);
      end
      chk("write_queue_drained", 64'(wq.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
